// File: rtl/pll_cfg_sequencer.sv
// Streams a table of 16-bit PLL configuration words to an SPI master and reports done/error.
// Optional lock supervision with retries is built when PLL_LOCK_CHECK_EN is defined.
module pll_cfg_sequencer #(
  parameter int NUM_WORDS    = 20,
  parameter int LOCK_TIMEOUT = 20000,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk_20Mz_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        spi_busy_i,
  output logic        spi_en,
  output logic [15:0] spi_tx_data,
  output logic [4:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  input  logic        pll_lock_i,
  output logic        busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o
);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, SEND, WAIT_ACK, WAIT_DONE, LOCK_WAIT, DONE, ERROR
  } state_t;

  localparam logic [4:0] LAST_IDX    = 5'(NUM_WORDS - 1);
  localparam logic [3:0] ACK_TIMEOUT = 4'd8;

  state_t      state, state_nxt;
  logic [4:0]  word_idx, word_idx_nxt;
  logic [3:0]  ack_cnt, ack_cnt_nxt;
  logic        spi_en_nxt;
  logic        tx_load;
  logic        done_nxt, err_nxt;

`ifdef PLL_LOCK_CHECK_EN
  localparam int LW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic          lock_meta, lock_sync;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic [RW-1:0] retry_cnt, retry_cnt_nxt;
`else
  logic          unused_lock;
  assign unused_lock = pll_lock_i;
`endif

  assign rom_addr_o = word_idx;
  assign busy_o     = !(state inside {IDLE, DONE, ERROR});

  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    ack_cnt_nxt  = ack_cnt;
    spi_en_nxt   = 1'b0;
    tx_load      = 1'b0;
    done_nxt     = cfg_done_o;
    err_nxt      = cfg_err_o;
`ifdef PLL_LOCK_CHECK_EN
    lock_cnt_nxt  = lock_cnt;
    retry_cnt_nxt = retry_cnt;
`endif
    case (state)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          word_idx_nxt = '0;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
`ifdef PLL_LOCK_CHECK_EN
          retry_cnt_nxt = '0;
`endif
          state_nxt    = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        tx_load   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (!spi_busy_i) begin
          spi_en_nxt  = 1'b1;
          ack_cnt_nxt = '0;
          state_nxt   = WAIT_ACK;
        end
      end
      // busy is sampled during the pulse cycle and the 8 cycles after it
      WAIT_ACK: begin
        if (spi_busy_i) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == ACK_TIMEOUT) begin
          err_nxt   = 1'b1;
          state_nxt = ERROR;
        end else begin
          ack_cnt_nxt = ack_cnt + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy_i) begin
          if (word_idx == LAST_IDX) begin
`ifdef PLL_LOCK_CHECK_EN
            lock_cnt_nxt = '0;
            state_nxt    = LOCK_WAIT;
`else
            done_nxt  = 1'b1;
            state_nxt = DONE;
`endif
          end else begin
            word_idx_nxt = word_idx + 5'd1;
            state_nxt    = FETCH;
          end
        end
      end
`ifdef PLL_LOCK_CHECK_EN
      LOCK_WAIT: begin
        if (lock_sync) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt_nxt = retry_cnt + 1'b1;
            word_idx_nxt  = '0;
            state_nxt     = FETCH;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERROR;
          end
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_20Mz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      word_idx    <= '0;
      ack_cnt     <= '0;
      spi_en      <= 1'b0;
      spi_tx_data <= '0;
      cfg_done_o  <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_idx   <= word_idx_nxt;
      ack_cnt    <= ack_cnt_nxt;
      spi_en     <= spi_en_nxt;
      cfg_done_o <= done_nxt;
      cfg_err_o  <= err_nxt;
      if (tx_load) spi_tx_data <= rom_data_i;
    end
  end

`ifdef PLL_LOCK_CHECK_EN
  // pll_lock_i is asynchronous to clk_20Mz_i, hence the two-flop synchronizer
  always_ff @(posedge clk_20Mz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      lock_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_sync <= lock_meta;
      lock_cnt  <= lock_cnt_nxt;
      retry_cnt <= retry_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Scoreboard bench for pll_cfg_sequencer: expected SPI words are queued at start,
// a monitor pops them on every spi_en pulse. Lock tests build with PLL_LOCK_CHECK_EN.
`timescale 1ns/1ps
module tb_pll_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        spi_busy = 1'b0;
  logic        spi_en;
  logic [15:0] spi_tx_data;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic        pll_lock;
  logic        busy, cfg_done, cfg_err;

  logic        respond = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic        prev_en = 1'b0;
  logic [15:0] sb[$];

  logic [15:0] rom_tbl [20] = '{
    16'h1A01, 16'h2B02, 16'h3C03, 16'h4D04, 16'h5E05,
    16'h6F06, 16'h7007, 16'h8108, 16'h9209, 16'hA30A,
    16'hB40B, 16'hC50C, 16'hD60D, 16'hE70E, 16'hF80F,
    16'h0910, 16'h1A11, 16'h2B12, 16'h3C13, 16'hFFEE
  };

  pll_cfg_sequencer #(.NUM_WORDS(20), .LOCK_TIMEOUT(1000), .MAX_RETRY(3)) dut (
    .clk_20Mz_i (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .spi_busy_i (spi_busy),
    .spi_en     (spi_en),
    .spi_tx_data(spi_tx_data),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .pll_lock_i (pll_lock),
    .busy_o     (busy),
    .cfg_done_o (cfg_done),
    .cfg_err_o  (cfg_err)
  );

  always #25 clk = ~clk;

  // synchronous ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= (int'(rom_addr) < 20) ? rom_tbl[int'(rom_addr)] : 16'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // SPI master model: busy rises 2 cycles after spi_en and stays up 40 cycles
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && spi_en && respond) begin
        repeat (2) @(negedge clk);
        spi_busy = 1'b1;
        repeat (40) @(negedge clk);
        spi_busy = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] exp_word;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_en = 1'b0;
      end else begin
        if (spi_en) begin
          pulse_cnt++;
          checkOutput("spi_en_width", {31'd0, prev_en}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_spi_en actual=%0h expected=none", spi_tx_data);
          end else begin
            exp_word = sb.pop_front();
            checkOutput("spi_tx_data", {16'd0, spi_tx_data}, {16'd0, exp_word});
          end
        end
        prev_en = spi_en;
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 20; i++) sb.push_back(rom_tbl[i]);
    pulseStart();
  endtask

  task automatic waitPulses(input int target, input string name);
    int n = 0;
    while (pulse_cnt < target && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(name, {31'd0, pulse_cnt >= target}, 32'd1);
  endtask

  task automatic waitEnd(input int bound, output int n);
    n = 0;
    while (!cfg_done && !cfg_err && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int base;
    int n;
    rstn     = 1'b0;
    start    = 1'b0;
    pll_lock = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_spi_en", {31'd0, spi_en}, 32'd0);
    checkOutput("rst_tx_data", {16'd0, spi_tx_data}, 32'd0);
    checkOutput("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    $display("[TB] full sequence with an ignored start during word 5");
    base = pulse_cnt;
    applyStimulus(1);
    checkOutput("A_busy", {31'd0, busy}, 32'd1);
    waitPulses(base + 6, "A_reach_word5");
    pulseStart();
    waitEnd(3000, n);
    checkOutput("A_done", {31'd0, cfg_done}, 32'd1);
    checkOutput("A_err", {31'd0, cfg_err}, 32'd0);
    checkOutput("A_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("A_pulses", pulse_cnt - base, 32'd20);
    checkOutput("A_sb_empty", sb.size(), 32'd0);
    checkOutput("A_last_addr", {27'd0, rom_addr}, 32'd19);
    checkOutput("A_last_word", {16'd0, spi_tx_data}, 32'h0000FFEE);

    $display("[TB] SPI never acknowledges");
    respond = 1'b0;
    base = pulse_cnt;
    sb.push_back(rom_tbl[0]);
    pulseStart();
    checkOutput("B_done_cleared", {31'd0, cfg_done}, 32'd0);
    waitPulses(base + 1, "B_first_pulse");
    n = 0;
    while (!cfg_err && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("B_err_latency", n, 32'd9);
    checkOutput("B_err", {31'd0, cfg_err}, 32'd1);
    checkOutput("B_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("B_busy", {31'd0, busy}, 32'd0);
    checkOutput("B_pulses", pulse_cnt - base, 32'd1);
    respond = 1'b1;

    $display("[TB] reset during word 10");
    base = pulse_cnt;
    applyStimulus(1);
    checkOutput("C_err_cleared", {31'd0, cfg_err}, 32'd0);
    waitPulses(base + 11, "C_reach_word10");
    checkOutput("C_en_before_rst", {31'd0, spi_en}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    checkOutput("C_rst_spi_en", {31'd0, spi_en}, 32'd0);
    checkOutput("C_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("C_rst_tx_data", {16'd0, spi_tx_data}, 32'd0);
    checkOutput("C_rst_rom_addr", {27'd0, rom_addr}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    base = pulse_cnt;
    repeat (200) @(negedge clk);
    #1;
    checkOutput("C_no_pulses_idle", pulse_cnt - base, 32'd0);
    checkOutput("C_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("C_idle_done", {31'd0, cfg_done}, 32'd0);
    applyStimulus(1);
    waitEnd(3000, n);
    checkOutput("C_done", {31'd0, cfg_done}, 32'd1);
    checkOutput("C_pulses", pulse_cnt - base, 32'd20);
    checkOutput("C_sb_empty", sb.size(), 32'd0);

`ifdef PLL_LOCK_CHECK_EN
    $display("[TB] lock arrives 500 cycles after the last word");
    pll_lock = 1'b0;
    base = pulse_cnt;
    applyStimulus(1);
    waitPulses(base + 20, "D_all_words");
    n = 0;
    while (!spi_busy && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    n = 0;
    while (spi_busy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (500) @(negedge clk);
    checkOutput("D_waiting_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("D_waiting_busy", {31'd0, busy}, 32'd1);
    pll_lock = 1'b1;
    n = 0;
    while (!cfg_done && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("D_lock_latency", n, 32'd3);
    checkOutput("D_err", {31'd0, cfg_err}, 32'd0);
    checkOutput("D_pulses", pulse_cnt - base, 32'd20);

    $display("[TB] lock never arrives");
    pll_lock = 1'b0;
    base = pulse_cnt;
    applyStimulus(4);
    waitEnd(12000, n);
    checkOutput("E_err", {31'd0, cfg_err}, 32'd1);
    checkOutput("E_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("E_pulses", pulse_cnt - base, 32'd80);
    checkOutput("E_sb_empty", sb.size(), 32'd0);
    checkOutput("E_busy", {31'd0, busy}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
